// File: rtl/adc_sar_sequencer_if.sv
// Control/data bundle between a SAR sequencer and its analog front end / host.
// The slave modport belongs to the sequencer. The master modport belongs to whoever drives it.
interface adc_sar_sequencer_if #(
    parameter int NBITS  = 10,
    parameter int SAMP_W = 4
);
    logic              start_i;
    logic              cont_i;
    logic [SAMP_W-1:0] samp_cycles_i;
    logic              cmp_i;
    logic              sample_o;
    logic [NBITS-1:0]  dac_o;
    logic [NBITS-1:0]  data_o;
    logic              valid_o;
    logic              busy_o;
    logic              overrun_o;

    modport slave (
        input  start_i, cont_i, samp_cycles_i, cmp_i,
        output sample_o, dac_o, data_o, valid_o, busy_o, overrun_o
    );

    modport master (
        output start_i, cont_i, samp_cycles_i, cmp_i,
        input  sample_o, dac_o, data_o, valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/adc_sar_sequencer.sv
// SAR ADC sequencer: track/hold sample phase, then binary search on the DAC code.
//   state   | meaning
//   IDLE    | waiting for start_i, switch open, DAC parked at 0
//   SAMPLE  | switch closed for the latched N cycles
//   CONVERT | one comparator decision per cycle, MSB first
//   DONE    | result published with a one-cycle valid_o pulse
module adc_sar_sequencer #(
    parameter int NBITS  = 10,
    parameter int SAMP_W = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    adc_sar_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t            state_q;
    logic [SAMP_W-1:0] cnt_q;
    logic [SAMP_W-1:0] samp_load_d;
    logic [NBITS-1:0]  mask_q;
    logic [NBITS-1:0]  dac_q;
    logic [NBITS-1:0]  dac_d;
    logic [NBITS-1:0]  data_q;
    logic              sample_q;
    logic              valid_q;
    logic              busy_q;
    logic              overrun_q;

    // Sample timer counts down to zero, so it is loaded with N-1 (a request of 0 behaves as 1).
    // mask_q is one-hot on the current trial bit.
    always_comb begin
        samp_load_d = (bus.samp_cycles_i == '0) ? '0 : bus.samp_cycles_i - SAMP_W'(1);
        dac_d       = (dac_q & ~mask_q) | (bus.cmp_i ? mask_q : '0) | (mask_q >> 1);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            dac_q     <= '0;
            data_q    <= '0;
            sample_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q  <= SAMPLE;
                        cnt_q    <= samp_load_d;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                SAMPLE: begin
                    overrun_q <= overrun_q | bus.start_i;
                    if (cnt_q == '0) begin
                        state_q  <= CONVERT;
                        sample_q <= 1'b0;
                        dac_q    <= NBITS'(1) << (NBITS - 1);
                        mask_q   <= NBITS'(1) << (NBITS - 1);
                    end else begin
                        cnt_q <= cnt_q - SAMP_W'(1);
                    end
                end
                CONVERT: begin
                    overrun_q <= overrun_q | bus.start_i;
                    dac_q     <= dac_d;
                    if (mask_q[0]) begin
                        state_q <= DONE;
                        data_q  <= dac_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        mask_q <= mask_q >> 1;
                    end
                end
                DONE: begin
                    dac_q <= '0;
                    if (bus.cont_i || bus.start_i) begin
                        state_q  <= SAMPLE;
                        cnt_q    <= samp_load_d;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sample_o  = sample_q;
    assign bus.dac_o     = dac_q;
    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Directed and randomized bench for adc_sar_sequencer with an ideal comparator model.
module tb_adc_sar_sequencer;
    localparam int NB = 10;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] vin = '0;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            valid_cyc = 0;
    int            prev_valid = 0;

    adc_sar_sequencer_if #(.NBITS(NB), .SAMP_W(SW)) bus_if ();

    adc_sar_sequencer #(.NBITS(NB), .SAMP_W(SW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Ideal comparator: Vin >= DAC
    assign bus_if.cmp_i = (vin >= bus_if.dac_o);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected trial code while bit i is being decided: decided upper bits of v plus bit i set.
    function automatic int trial(input int v, input int i);
        return ((v >> (i + 1)) << (i + 1)) | (1 << i);
    endfunction

    task automatic chk_idle(input string tag, input int data_exp);
        chk({tag, ".busy"},   32'(bus_if.busy_o),   0);
        chk({tag, ".sample"}, 32'(bus_if.sample_o), 0);
        chk({tag, ".dac"},    32'(bus_if.dac_o),    0);
        chk({tag, ".valid"},  32'(bus_if.valid_o),  0);
        chk({tag, ".data"},   32'(bus_if.data_o),   32'(data_exp));
    endtask

    // Called at a negedge just before the edge that enters SAMPLE; returns at the DONE-cycle negedge.
    task automatic conv(input logic [NB-1:0] v, input int n, input int ovr_at,
                        input int drop_at, input string tag);
        vin = v;
        tick();
        bus_if.start_i = 1'b0;
        bus_if.samp_cycles_i = SW'($urandom);
        for (int j = 0; j < n; j++) begin
            chk({tag, ".samp_sample"}, 32'(bus_if.sample_o), 1);
            chk({tag, ".samp_busy"},   32'(bus_if.busy_o),   1);
            chk({tag, ".samp_dac"},    32'(bus_if.dac_o),    0);
            chk({tag, ".samp_valid"},  32'(bus_if.valid_o),  0);
            tick();
        end
        for (int i = NB - 1; i >= 0; i--) begin
            chk({tag, ".conv_dac"},    32'(bus_if.dac_o),    32'(trial(int'(v), i)));
            chk({tag, ".conv_sample"}, 32'(bus_if.sample_o), 0);
            chk({tag, ".conv_busy"},   32'(bus_if.busy_o),   1);
            chk({tag, ".conv_valid"},  32'(bus_if.valid_o),  0);
            bus_if.start_i = (i == ovr_at);
            if (i == drop_at) bus_if.cont_i = 1'b0;
            tick();
        end
        bus_if.start_i = 1'b0;
        chk({tag, ".done_valid"},  32'(bus_if.valid_o),  1);
        chk({tag, ".done_data"},   32'(bus_if.data_o),   32'(v));
        chk({tag, ".done_dac"},    32'(bus_if.dac_o),    32'(v));
        chk({tag, ".done_busy"},   32'(bus_if.busy_o),   0);
        chk({tag, ".done_sample"}, 32'(bus_if.sample_o), 0);
        prev_valid = valid_cyc;
        valid_cyc  = cyc;
    endtask

    initial begin
        logic [NB-1:0] v;
        int            s;
        int            n;

        // Reset with random inputs
        bus_if.start_i       = 1'($urandom);
        bus_if.cont_i        = 1'($urandom);
        bus_if.samp_cycles_i = SW'($urandom);
        vin                  = NB'($urandom);
        rst = 1'b1;
        tick();
        tick();
        chk_idle("reset", 0);
        chk("reset.overrun", 32'(bus_if.overrun_o), 0);
        rst = 1'b0;
        bus_if.start_i = 1'b0;
        bus_if.cont_i  = 1'b0;
        tick();
        chk_idle("post_reset", 0);

        // Single conversion, N=3: valid lands 14 cycles after the start edge
        bus_if.samp_cycles_i = 4'd3;
        bus_if.start_i = 1'b1;
        conv(10'h2A5, 3, -1, -1, "single");
        tick();
        chk_idle("single_after", 'h2A5);

        // Extremes
        bus_if.samp_cycles_i = 4'd3;
        bus_if.start_i = 1'b1;
        conv(10'h3FF, 3, -1, -1, "ext3ff");
        tick();
        bus_if.samp_cycles_i = 4'd3;
        bus_if.start_i = 1'b1;
        conv(10'h000, 3, -1, -1, "ext000");
        tick();
        bus_if.samp_cycles_i = 4'd3;
        bus_if.start_i = 1'b1;
        conv(10'h200, 3, -1, -1, "ext200");
        tick();
        chk_idle("ext_after", 'h200);

        // Randomized conversions with random sample lengths, then data hold while idle
        for (int r = 0; r < 8; r++) begin
            v = NB'($urandom_range(0, (1 << NB) - 1));
            s = int'($urandom_range(0, (1 << SW) - 1));
            n = (s == 0) ? 1 : s;
            bus_if.samp_cycles_i = SW'(s);
            bus_if.start_i = 1'b1;
            conv(v, n, -1, -1, "rand");
            tick();
            chk_idle("rand_idle", int'(v));
            vin = NB'($urandom);
            tick();
            chk("rand_hold", 32'(bus_if.data_o), 32'(v));
        end
        chk("rand_no_overrun", 32'(bus_if.overrun_o), 0);

        // Continuous mode, samp_cycles=0: one result every 12 cycles, cont dropped mid-CONVERT
        bus_if.cont_i = 1'b1;
        bus_if.samp_cycles_i = '0;
        bus_if.start_i = 1'b1;
        conv(10'h100, 1, -1, -1, "cont0");
        bus_if.samp_cycles_i = '0;
        conv(10'h155, 1, -1, -1, "cont1");
        chk("cont1.period", 32'(valid_cyc - prev_valid), 12);
        bus_if.samp_cycles_i = '0;
        conv(10'h3FE, 1, -1, 4, "cont2");
        chk("cont2.period", 32'(valid_cyc - prev_valid), 12);
        tick();
        chk_idle("cont_idle", 'h3FE);
        tick();
        tick();
        chk_idle("cont_idle2", 'h3FE);

        // Overrun: start during CONVERT is dropped and flagged; start in DONE is accepted
        chk("ovr.pre", 32'(bus_if.overrun_o), 0);
        bus_if.samp_cycles_i = 4'd2;
        bus_if.start_i = 1'b1;
        conv(10'h0AB, 2, 5, -1, "ovr");
        chk("ovr.flag", 32'(bus_if.overrun_o), 1);
        bus_if.samp_cycles_i = 4'd1;
        bus_if.start_i = 1'b1;
        conv(10'h3C3, 1, -1, -1, "ovr_done");
        chk("ovr.sticky", 32'(bus_if.overrun_o), 1);
        tick();
        chk_idle("ovr_idle", 'h3C3);
        chk("ovr.sticky_idle", 32'(bus_if.overrun_o), 1);

        // Reset while deciding bit 5
        bus_if.samp_cycles_i = 4'd2;
        vin = 10'h155;
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
        tick();
        tick();
        for (int i = NB - 1; i > 5; i--) tick();
        chk("rstmid.dac_bit5", 32'(bus_if.dac_o), 32'(trial('h155, 5)));
        rst = 1'b1;
        tick();
        chk_idle("rstmid", 0);
        chk("rstmid.overrun", 32'(bus_if.overrun_o), 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rstmid.no_valid", 32'(bus_if.valid_o), 0);
        end
        chk_idle("rstmid_end", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_sar_sequencer.md
ADC_SAR_SEQUENCER -- requirements
Module: adc_sar_sequencer

Interface
REQ-001 Parameter NBITS, default 10: conversion resolution in bits.
REQ-002 Parameter SAMP_W, default 4: width of the sample-time field.
REQ-003 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  conversion request, sampled each edge.
REQ-006 cont_i  input  1  continuous mode: restart automatically after each result.
REQ-007 samp_cycles_i  input  SAMP_W  sample-phase length in cycles; value 0 is treated as 1.
REQ-008 cmp_i  input  1  comparator decision for the current dac_o: 1 means Vin >= DAC.
REQ-009 sample_o  output  1  track/hold switch closed.
REQ-010 dac_o  output  NBITS  current SAR trial code.
REQ-011 data_o  output  NBITS  last completed conversion result.
REQ-012 valid_o  output  1  one-cycle pulse; data_o is new in this cycle.
REQ-013 busy_o  output  1  conversion in progress.
REQ-014 overrun_o  output  1  sticky flag: a start request was dropped.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SAMPLE, CONVERT and DONE.
REQ-016 IDLE: sample_o=0, dac_o=0, busy_o=0; start_i=1 -> SAMPLE.
REQ-017 On entry to SAMPLE, the block SHALL latch max(samp_cycles_i,1) as N; later changes to samp_cycles_i SHALL have no effect until the next entry.
REQ-018 SAMPLE: sample_o=1, dac_o=0, busy_o=1 for exactly N cycles, then -> CONVERT.
REQ-019 On entry to CONVERT, dac_o SHALL equal 1<<(NBITS-1), and busy_o SHALL be 1.
REQ-020 Each CONVERT cycle with trial bit i, the block SHALL register cmp_i into bit i of the code (1 keeps the bit, 0 clears it) and set bit i-1 in the next cycle; higher decided bits SHALL be preserved.
REQ-021 CONVERT SHALL last exactly NBITS cycles; after the bit-0 decision the FSM SHALL go -> DONE.
REQ-022 DONE (one cycle): data_o = the final code, valid_o=1, sample_o=0, busy_o=0, dac_o holds the final code.
REQ-023 From DONE: cont_i=1 or start_i=1 -> SAMPLE (samp_cycles_i re-latched); otherwise -> IDLE.
REQ-024 Latency: if start_i is sampled at edge k, valid_o SHALL be high in cycle k+N+NBITS+1.
REQ-025 start_i=1 in SAMPLE or CONVERT SHALL be ignored and SHALL set overrun_o=1; the in-flight conversion SHALL be unaffected.
REQ-026 start_i=1 in DONE SHALL be accepted and SHALL NOT set overrun_o.
REQ-027 cont_i deasserted mid-conversion: the current conversion SHALL complete normally, then the FSM SHALL go -> IDLE (unless start_i=1 in DONE).
REQ-028 data_o SHALL hold its value between valid_o pulses.
REQ-029 overrun_o SHALL be cleared only by reset.

Reset
REQ-030 While wb_rst_i=1 at an edge, the block SHALL enter IDLE, with sample_o=0, dac_o=0, data_o=0, valid_o=0, busy_o=0 and overrun_o=0.
REQ-031 Reset SHALL take priority over all inputs in any state, including mid-SAMPLE or mid-CONVERT; no valid_o pulse SHALL be produced for an aborted conversion.

Verification
REQ-032 Reset check: assert wb_rst_i for 2 cycles with random inputs -> all outputs 0 and the FSM in IDLE.
REQ-033 Single conversion: bench comparator model cmp_i = (0x2A5 >= dac_o), samp_cycles_i=3, start_i pulse at edge k -> sample_o high in cycles k+1..k+3; dac_o 0x200 in cycle k+4; valid_o only in cycle k+14; data_o=0x2A5; busy_o low afterwards.
REQ-034 Extremes: Vin=0x3FF -> data_o=0x3FF; Vin=0x000 -> data_o=0x000; Vin=0x200 -> data_o=0x200.
REQ-035 Continuous mode: cont_i=1, samp_cycles_i=0, Vin stepping 0x100, 0x155, 0x3FE -> valid_o every 12 cycles with matching codes; cont_i dropped mid-CONVERT -> one more result, then IDLE.
REQ-036 Overrun: start_i pulse during CONVERT -> overrun_o=1, result unchanged; start_i in the DONE cycle -> new SAMPLE begins next cycle, overrun_o unchanged.
REQ-037 Reset mid-CONVERT: assert wb_rst_i at trial bit 5 -> next cycle in IDLE, dac_o=0, data_o=0, overrun_o=0, and no valid_o pulse.
